// File: rtl/pdm_tx.sv
// pdm_tx: PCM-to-PDM transmitter.
//   A 2-entry FIFO buffers 16-bit signed PCM samples. Each en_pdm strobe
//   linearly interpolates between the previous and current sample across
//   OSR phases. The result drives a saturating 2nd-order delta-sigma
//   modulator that emits one PDM bit per strobe.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   en_pdm     single-cycle strobe, one PDM bit period
//   pcm_in     signed PCM sample
//   pcm_valid  pcm_in holds a valid sample
//   pcm_ready  FIFO not full (registered state only)
//   pdm_out    registered PDM bit
//   underrun   one-cycle pulse: sample boundary reached with the FIFO empty
module pdm_tx #(
    parameter int unsigned OSR   = 128,
    parameter int unsigned ACC_W = 24
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en_pdm,
    input  logic [15:0] pcm_in,
    input  logic        pcm_valid,
    output logic        pcm_ready,
    output logic        pdm_out,
    output logic        underrun
);

    localparam int unsigned PH_W   = $clog2(OSR);
    localparam int unsigned PROD_W = 17 + PH_W + 1;
    // Two guard bits: |i| + |x| + |fb| cannot overflow before saturation.
    localparam int unsigned SUM_W  = ACC_W + 2;

    localparam logic signed [SUM_W-1:0] FB_MAG  = SUM_W'(32768);
    localparam logic signed [SUM_W-1:0] ACC_MAX = SUM_W'((64'd1 << (ACC_W - 1)) - 64'd1);
    localparam logic signed [SUM_W-1:0] ACC_MIN = -ACC_MAX;

    // FIFO
    logic [15:0] fifo_mem [2];
    logic        wr_ptr_q, rd_ptr_q;
    logic [1:0]  count_q;
    logic        push, pop;

    // Interpolator and modulator state
    logic [PH_W-1:0]          phase_q;
    logic signed [15:0]       prev_q, cur_q;
    logic signed [ACC_W-1:0]  i1_q, i2_q;

    logic                     boundary;
    logic signed [16:0]       diff;
    logic signed [PROD_W-1:0] prod, prod_sh;
    logic signed [16:0]       x;
    logic signed [SUM_W-1:0]  x_ext, fb, i1_sum, i2_sum;
    logic signed [ACC_W-1:0]  i1_sat, i2_sat;

    function automatic logic signed [ACC_W-1:0] sat(input logic signed [SUM_W-1:0] v);
        if (v > ACC_MAX) begin
            return ACC_W'(ACC_MAX);
        end else if (v < ACC_MIN) begin
            return ACC_W'(ACC_MIN);
        end
        return ACC_W'(v);
    endfunction

    assign pcm_ready = (count_q != 2'd2);
    assign push      = pcm_valid & pcm_ready;
    assign boundary  = en_pdm & (phase_q == PH_W'(OSR - 1));
    assign pop       = boundary & (count_q != 2'd0);

    // x = prev + floor((cur - prev) * phase / OSR); stays between prev and cur.
    always_comb begin
        diff    = $signed({cur_q[15], cur_q}) - $signed({prev_q[15], prev_q});
        prod    = $signed({{(PROD_W - 17){diff[16]}}, diff})
                * $signed({{(PROD_W - PH_W){1'b0}}, phase_q});
        prod_sh = prod >>> PH_W;
        x       = $signed({prev_q[15], prev_q}) + 17'(prod_sh);
        x_ext   = $signed({{(SUM_W - 17){x[16]}}, x});
        fb      = pdm_out ? FB_MAG : -FB_MAG;
        i1_sum  = $signed({{2{i1_q[ACC_W-1]}}, i1_q}) + x_ext - fb;
        i1_sat  = sat(i1_sum);
        i2_sum  = $signed({{2{i2_q[ACC_W-1]}}, i2_q})
                + $signed({{2{i1_sat[ACC_W-1]}}, i1_sat}) - fb;
        i2_sat  = sat(i2_sum);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fifo_mem[0] <= '0;
            fifo_mem[1] <= '0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            count_q     <= 2'd0;
            phase_q     <= '0;
            prev_q      <= '0;
            cur_q       <= '0;
            i1_q        <= '0;
            i2_q        <= '0;
            pdm_out     <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            underrun <= 1'b0;

            if (push) begin
                fifo_mem[wr_ptr_q] <= pcm_in;
                wr_ptr_q           <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: ;
            endcase

            if (en_pdm) begin
                i1_q    <= i1_sat;
                i2_q    <= i2_sat;
                pdm_out <= ~i2_sat[ACC_W-1];
                if (boundary) begin
                    phase_q <= '0;
                    prev_q  <= cur_q;
                    if (count_q != 2'd0) begin
                        cur_q <= $signed(fifo_mem[rd_ptr_q]);
                    end else begin
                        // Hold the last sample and flag the starvation.
                        underrun <= 1'b1;
                    end
                end else begin
                    phase_q <= phase_q + PH_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_pdm_tx.sv
// tb_pdm_tx: randomized, scoreboard-checked bench for pdm_tx.
//   A behavioural model (integer arithmetic, queue FIFO) predicts each PDM
//   bit and underrun flag per strobe; a monitor pops and compares them.
module tb_pdm_tx;

    localparam int OSR     = 128;
    localparam int ACC_W   = 20;
    localparam longint ACC_MAX = (64'sd1 <<< (ACC_W - 1)) - 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en_pdm = 1'b0;
    logic [15:0] pcm_in = '0;
    logic        pcm_valid = 1'b0;
    logic        pcm_ready, pdm_out, underrun;

    pdm_tx #(.OSR(OSR), .ACC_W(ACC_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .en_pdm    (en_pdm),
        .pcm_in    (pcm_in),
        .pcm_valid (pcm_valid),
        .pcm_ready (pcm_ready),
        .pdm_out   (pdm_out),
        .underrun  (underrun)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic signed [63:0] act,
                         input logic signed [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input longint act,
                               input longint lo, input longint hi);
        n_checks++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d..%0d", name, act, lo, hi);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        bit pdm;
        bit ur;
    } exp_t;

    int     m_prev = 0, m_cur = 0, m_phase = 0;
    longint m_i1 = 0, m_i2 = 0;
    bit     m_pdm = 0, m_ready = 1;
    int     m_fifo[$];
    exp_t   exp_q[$];

    function automatic longint clip(input longint v);
        if (v > ACC_MAX) return ACC_MAX;
        if (v < -ACC_MAX) return -ACC_MAX;
        return v;
    endfunction

    // Linear interpolation rounded toward minus infinity.
    function automatic int interp(input int p, input int c, input int ph);
        longint d, q;
        d = longint'(c - p) * ph;
        q = d / OSR;
        if (d < 0 && (d % OSR) != 0) q = q - 1;
        return p + int'(q);
    endfunction

    always @(posedge clk or posedge rst) begin : model
        bit     do_push, ur;
        int     xv;
        longint fbv, i1n, i2n;
        if (rst) begin
            m_prev = 0; m_cur = 0; m_phase = 0;
            m_i1 = 0; m_i2 = 0; m_pdm = 0; m_ready = 1;
            m_fifo.delete();
            exp_q.delete();
        end else begin
            do_push = pcm_valid && (m_fifo.size() < 2);
            if (en_pdm) begin
                xv  = interp(m_prev, m_cur, m_phase);
                fbv = m_pdm ? 32768 : -32768;
                i1n = clip(m_i1 + xv - fbv);
                i2n = clip(m_i2 + i1n - fbv);
                m_i1 = i1n;
                m_i2 = i2n;
                m_pdm = (i2n >= 0);
                ur = 0;
                if (m_phase == OSR - 1) begin
                    m_phase = 0;
                    m_prev = m_cur;
                    if (m_fifo.size() > 0) m_cur = m_fifo.pop_front();
                    else ur = 1;
                end else begin
                    m_phase++;
                end
                exp_q.push_back('{pdm: m_pdm, ur: ur});
            end
            if (do_push) m_fifo.push_back(int'($signed(pcm_in)));
            m_ready = (m_fifo.size() < 2);
        end
    end

    // ---------------- monitor ----------------
    int   ones_cnt = 0, bits_cnt = 0, ur_cnt = 0;
    int   zero_run = 0, max_zero_run = 0;
    bit   step_mode = 0;
    int   step_hits = 0;
    exp_t e;

    always @(negedge clk) begin
        if (rst) begin
            check("rst_pdm_out", pdm_out, 0);
            check("rst_pcm_ready", pcm_ready, 1);
            check("rst_underrun", underrun, 0);
        end else begin
            check("pcm_ready", pcm_ready, m_ready);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("pdm_out", pdm_out, e.pdm);
                check("underrun", underrun, e.ur);
                bits_cnt++;
                ones_cnt += int'(pdm_out);
                ur_cnt   += int'(underrun);
                if (pdm_out) zero_run = 0;
                else zero_run++;
                if (zero_run > max_zero_run) max_zero_run = zero_run;
                if (exp_q.size() != 0) begin
                    check("scoreboard_backlog", exp_q.size(), 0);
                    exp_q.delete();
                end
            end else begin
                check("underrun_idle", underrun, 0);
            end
            if (step_mode && en_pdm) begin
                if (m_prev == 0 && m_cur == 32767) begin
                    if (m_phase == 0) begin
                        check("x_phase0", dut.x, 0); step_hits++;
                    end else if (m_phase == 64) begin
                        check("x_phase64", dut.x, 16383); step_hits++;
                    end else if (m_phase == 127) begin
                        check("x_phase127", dut.x, 32511); step_hits++;
                    end
                end
                check_range("i1_limit", longint'(dut.i1_q), -ACC_MAX, ACC_MAX);
                check_range("i2_limit", longint'(dut.i2_q), -ACC_MAX, ACC_MAX);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_stats();
        ones_cnt = 0; bits_cnt = 0; ur_cnt = 0; zero_run = 0; max_zero_run = 0;
    endtask

    task automatic do_reset();
        en_pdm = 0; pcm_valid = 0;
        rst = 1;
        tick(); tick();
        rst = 0;
        clear_stats();
    endtask

    // mode 0: no input, 1: constant val held valid, 2: random valid/data.
    // period 0 picks a random strobe spacing of 1..4 clocks.
    task automatic run(input int n, input int period, input int mode, input int val);
        for (int s = 0; s < n; s++) begin
            int per;
            per = (period == 0) ? int'($urandom_range(1, 4)) : period;
            for (int c = 0; c < per; c++) begin
                en_pdm = (c == per - 1);
                case (mode)
                    1: begin pcm_valid = 1; pcm_in = 16'(val); end
                    2: begin pcm_valid = 1'($urandom_range(0, 1)); pcm_in = 16'($urandom); end
                    default: pcm_valid = 0;
                endcase
                tick();
            end
        end
        en_pdm = 0; pcm_valid = 0;
        tick();
    endtask

    initial begin
        rst = 1;
        repeat (3) tick();
        rst = 0;
        tick();

        // Back-to-back pushes with no strobes: third is held off.
        check("ready_idle", pcm_ready, 1);
        pcm_valid = 1; pcm_in = 16'd111; tick();
        pcm_in = 16'd222; tick();
        check("ready_after_two", pcm_ready, 0);
        pcm_in = 16'd333; tick(); tick();
        check("ready_held", pcm_ready, 0);
        run(130, 2, 1, 333);
        check("ready_refilled", pcm_ready, 0);
        run(300, 2, 0, 0);

        // Constant zero, strobe every 20 clocks.
        do_reset();
        run(1024, 20, 1, 0);
        check_range("zero_ones", ones_cnt, 509, 515);
        check("zero_underruns", ur_cnt, 0);
        check("zero_bits", bits_cnt, 1024);

        // +/- half scale.
        do_reset();
        run(256, 3, 1, 16384);
        clear_stats();
        run(1024, 3, 1, 16384);
        check_range("pos_half_ones", ones_cnt, 764, 772);
        do_reset();
        run(256, 3, 1, -16384);
        clear_stats();
        run(1024, 3, 1, -16384);
        check_range("neg_half_ones", ones_cnt, 252, 260);

        // Single sample then starvation.
        do_reset();
        pcm_valid = 1; pcm_in = 16'd1000; tick();
        pcm_valid = 0;
        run(256, 3, 0, 0);
        check("underrun_first", ur_cnt, 1);
        clear_stats();
        run(256, 3, 0, 0);
        check("underrun_second", ur_cnt, 2);
        check_range("hold_1000_ones", ones_cnt, 128, 136);

        // Full-scale step 0 -> 32767 exercised through the interpolator.
        do_reset();
        step_mode = 1;
        run(256, 2, 1, 32767);
        step_mode = 0;
        check("step_points_seen", step_hits, 3);

        // Negative full scale, then recovery to mid-scale without lock-up.
        do_reset();
        run(512, 3, 1, -32768);
        run(384, 3, 1, 0);
        clear_stats();
        run(256, 3, 1, 0);
        check_range("recover_max_zero_run", max_zero_run, 0, 63);
        check_range("recover_ones", ones_cnt, 96, 160);

        // Reset pulse mid-sample with the FIFO full.
        do_reset();
        pcm_valid = 1; pcm_in = 16'd5000; tick();
        pcm_in = 16'(-7000); tick();
        run(60, 2, 1, 1234);
        pcm_valid = 1; pcm_in = 16'd999; en_pdm = 1;
        rst = 1;
        tick();
        check("rst_pulse_pdm", pdm_out, 0);
        check("rst_pulse_ready", pcm_ready, 1);
        rst = 0; en_pdm = 0;
        pcm_in = 16'd4321; tick();
        pcm_in = 16'(-4321); tick();
        check("ready_after_release_pushes", pcm_ready, 0);
        pcm_valid = 0; en_pdm = 1; tick();
        en_pdm = 0;
        @(negedge clk);
        #1;
        check("first_bit_after_reset", pdm_out, 1);
        tick();
        run(300, 0, 2, 0);

        // Random traffic.
        do_reset();
        run(1500, 0, 2, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
